// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared decoded control-word layout for the MIPS pipeline
//
// Field positions of the 23-bit decoded control word, its width, and a packed
// struct with the same layout for readable construction and decoding.

package mips_pkg;

   localparam int CTRL_W    = 23;

   localparam int RS_HI     = 22;
   localparam int RS_LO     = 18;
   localparam int RT_HI     = 17;
   localparam int RT_LO     = 13;
   localparam int RD_HI     = 12;
   localparam int RD_LO     = 8;
   localparam int WE_BIT    = 7;
   localparam int ALU1_BIT  = 6;
   localparam int SEL_HI    = 5;
   localparam int SEL_LO    = 4;
   localparam int MUL_BIT   = 3;
   localparam int ALU2_BIT  = 2;
   localparam int MEMWR_BIT = 1;
   localparam int WBSEL_BIT = 0;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       we;
      logic       alu1_mux;
      logic [1:0] sel_alu;
      logic       mul_st;
      logic       alu2_mux;
      logic       mem_wr;
      logic       mux_sel_wb;
   } ctrl_t;

endpackage

// File: rtl/hazard_chk.sv
// rtl/hazard_chk.sv - combinational read-after-write hazard detector
//
// Ports:
//   dec_valid, dec_word            : candidate word from the decoder
//   ex_/mem_/wb_valid, _word       : in-flight stage registers
//   hazard                         : decoder word reads a register still being
//                                    written by EX, MEM or WB

module hazard_chk
   import mips_pkg::*;
(
   input  logic              dec_valid,
   input  logic [CTRL_W-1:0] dec_word,
   input  logic              ex_valid,
   input  logic [CTRL_W-1:0] ex_word,
   input  logic              mem_valid,
   input  logic [CTRL_W-1:0] mem_word,
   input  logic              wb_valid,
   input  logic [CTRL_W-1:0] wb_word,
   output logic              hazard
);

   logic [4:0] w_rs;
   logic [4:0] w_rt;
   logic       w_rt_src;
   logic [4:0] w_ex_rd;
   logic [4:0] w_mem_rd;
   logic [4:0] w_wb_rd;
   logic       w_ex_hit;
   logic       w_mem_hit;
   logic       w_wb_hit;
   logic       w_unused;

   function automatic logic stage_hit(
      input logic       v,
      input logic       we,
      input logic [4:0] rd,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       rt_src
   );
      // r0 is hard-wired, so a write to it never blocks a reader
      return v && we && (rd != 5'd0) && ((rd == rs) || (rt_src && (rd == rt)));
   endfunction

   assign w_rs     = dec_word[RS_HI:RS_LO];
   assign w_rt     = dec_word[RT_HI:RT_LO];
   // A load names its destination in rt, so rt is not read
   assign w_rt_src = !(dec_word[WE_BIT] && dec_word[ALU1_BIT]);

   assign w_ex_rd  = ex_word[RD_HI:RD_LO];
   assign w_mem_rd = mem_word[RD_HI:RD_LO];
   assign w_wb_rd  = wb_word[RD_HI:RD_LO];

   assign w_ex_hit  = stage_hit(ex_valid,  ex_word[WE_BIT],  w_ex_rd,  w_rs, w_rt, w_rt_src);
   assign w_mem_hit = stage_hit(mem_valid, mem_word[WE_BIT], w_mem_rd, w_rs, w_rt, w_rt_src);
   // WB counts too: the register file is written at the end of WB, no bypass
   assign w_wb_hit  = stage_hit(wb_valid,  wb_word[WE_BIT],  w_wb_rd,  w_rs, w_rt, w_rt_src);

   assign hazard = dec_valid && (w_ex_hit || w_mem_hit || w_wb_hit);

   assign w_unused = ^{dec_word[RD_HI:RD_LO], dec_word[SEL_HI:0],
                       ex_word[RS_HI:RT_LO],  ex_word[ALU1_BIT:0],
                       mem_word[RS_HI:RT_LO], mem_word[ALU1_BIT:0],
                       wb_word[RS_HI:RT_LO],  wb_word[ALU1_BIT:0]};

endmodule

// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - EX/MEM/WB stage scheduler with RAW stall and multiply hold
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   dec_valid, dec_word            : decoded control word from ID
//   dec_ready                      : word accepted this cycle (IF/ID holds when low)
//   ex_/mem_/wb_valid, _word       : stage registers
//   wb_we                          : register-file write strobe
//   mul_busy                       : EX is holding a multiply
//   hazard_stall                   : RAW hazard seen this cycle

module pipe_sched
   import mips_pkg::*;
#(
   parameter int MUL_CYCLES = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_valid,
   input  logic [CTRL_W-1:0] dec_word,
   output logic              dec_ready,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_word,
   output logic              mem_valid,
   output logic [CTRL_W-1:0] mem_word,
   output logic              wb_valid,
   output logic [CTRL_W-1:0] wb_word,
   output logic              wb_we,
   output logic              mul_busy,
   output logic              hazard_stall
);

   localparam logic [3:0] L_MUL_INIT = 4'(MUL_CYCLES - 1);

   logic              r_ex_valid;
   logic [CTRL_W-1:0] r_ex_word;
   logic              r_mem_valid;
   logic [CTRL_W-1:0] r_mem_word;
   logic              r_wb_valid;
   logic [CTRL_W-1:0] r_wb_word;
   logic [3:0]        r_mul_cnt;

   logic              w_hazard;
   logic              w_ex_hold;

   hazard_chk u_hazard_chk (
      .dec_valid (dec_valid),
      .dec_word  (dec_word),
      .ex_valid  (r_ex_valid),
      .ex_word   (r_ex_word),
      .mem_valid (r_mem_valid),
      .mem_word  (r_mem_word),
      .wb_valid  (r_wb_valid),
      .wb_word   (r_wb_word),
      .hazard    (w_hazard)
   );

   assign w_ex_hold = (r_mul_cnt != 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid  <= 1'b0;
         r_ex_word   <= '0;
         r_mem_valid <= 1'b0;
         r_mem_word  <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_word   <= '0;
         r_mul_cnt   <= 4'd0;
      end else if (w_ex_hold) begin
         // Multiply occupies EX; the hold wins over any pending hazard and
         // MEM fills with bubbles while older work drains to WB
         r_mul_cnt   <= r_mul_cnt - 4'd1;
         r_mem_valid <= 1'b0;
         r_mem_word  <= '0;
         r_wb_valid  <= r_mem_valid;
         r_wb_word   <= r_mem_word;
      end else begin
         r_wb_valid  <= r_mem_valid;
         r_wb_word   <= r_mem_word;
         r_mem_valid <= r_ex_valid;
         r_mem_word  <= r_ex_word;
         if (w_hazard) begin
            r_ex_valid <= 1'b0;
            r_ex_word  <= '0;
         end else begin
            r_ex_valid <= dec_valid;
            r_ex_word  <= dec_word;
            if (dec_valid && dec_word[MUL_BIT]) begin
               r_mul_cnt <= L_MUL_INIT;
            end
         end
      end
   end

   assign dec_ready    = !(w_hazard || w_ex_hold);
   assign hazard_stall = w_hazard;
   assign mul_busy     = w_ex_hold;
   assign ex_valid     = r_ex_valid;
   assign ex_word      = r_ex_word;
   assign mem_valid    = r_mem_valid;
   assign mem_word     = r_mem_word;
   assign wb_valid     = r_wb_valid;
   assign wb_word      = r_wb_word;
   assign wb_we        = r_wb_valid && r_wb_word[WE_BIT];

endmodule

// File: tb/tb_pipe_sched.sv
// tb/tb_pipe_sched.sv - directed self-checking bench for pipe_sched

module tb_pipe_sched;
   import mips_pkg::*;

   logic              clk;
   logic              rst;
   logic              dec_valid;
   logic [CTRL_W-1:0] dec_word;
   logic              dec_ready;
   logic              ex_valid;
   logic [CTRL_W-1:0] ex_word;
   logic              mem_valid;
   logic [CTRL_W-1:0] mem_word;
   logic              wb_valid;
   logic [CTRL_W-1:0] wb_word;
   logic              wb_we;
   logic              mul_busy;
   logic              hazard_stall;

   int checks   = 0;
   int failures = 0;

   logic [CTRL_W-1:0] sb[$];
   logic              last_acc;
   int                hz_cnt;
   int                we_cnt;
   logic [4:0]        last_we_rd;

   pipe_sched #(.MUL_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .dec_valid    (dec_valid),
      .dec_word     (dec_word),
      .dec_ready    (dec_ready),
      .ex_valid     (ex_valid),
      .ex_word      (ex_word),
      .mem_valid    (mem_valid),
      .mem_word     (mem_word),
      .wb_valid     (wb_valid),
      .wb_word      (wb_word),
      .wb_we        (wb_we),
      .mul_busy     (mul_busy),
      .hazard_stall (hazard_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CTRL_W-1:0] mk(input int rs, input int rt, input int rd,
                                            input logic we, input logic alu1,
                                            input logic mul, input logic memwr);
      ctrl_t c;
      c          = '0;
      c.rs       = 5'(rs);
      c.rt       = 5'(rt);
      c.rd       = 5'(rd);
      c.we       = we;
      c.alu1_mux = alu1;
      c.mul_st   = mul;
      c.mem_wr   = memwr;
      return c;
   endfunction

   // One clock: sample acceptance just before the edge, then check WB
   // against the scoreboard just after it.
   task automatic tick();
      logic              acc;
      logic              r;
      logic [CTRL_W-1:0] w;
      logic [CTRL_W-1:0] exp;
      #1;
      r   = rst;
      acc = dec_valid && dec_ready && !rst;
      w   = dec_word;
      if (dec_valid && hazard_stall) hz_cnt++;
      @(posedge clk);
      #1;
      last_acc = acc;
      if (r) sb.delete();
      if (acc) sb.push_back(w);
      if (wb_we) begin
         we_cnt++;
         last_we_rd = wb_word[RD_HI:RD_LO];
      end
      if (wb_valid) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected", {9'd0, wb_word}, 32'd0);
         end else begin
            exp = sb.pop_front();
            chk("wb_order", {9'd0, wb_word}, {9'd0, exp});
         end
      end
   endtask

   task automatic issue(input logic [CTRL_W-1:0] w, output int stalls);
      logic done;
      dec_valid = 1'b1;
      dec_word  = w;
      stalls    = 0;
      done      = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         tick();
         if (last_acc) done = 1'b1;
         else stalls++;
      end
      if (!done) chk("issue_timeout", 32'd0, 32'd1);
      dec_valid = 1'b0;
      dec_word  = '0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int                stalls;
      int                ex_same;
      int                busy;
      int                mem_bub;
      logic              done;
      logic [CTRL_W-1:0] ld3, add3, ld0, add0, ld5, st5, mul7, add7, addf;

      ld3  = mk(1, 3, 3, 1'b1, 1'b1, 1'b0, 1'b0);
      add3 = mk(3, 2, 4, 1'b1, 1'b0, 1'b0, 1'b0);
      ld0  = mk(1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      add0 = mk(0, 6, 4, 1'b1, 1'b0, 1'b0, 1'b0);
      ld5  = mk(1, 5, 5, 1'b1, 1'b1, 1'b0, 1'b0);
      st5  = mk(1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      mul7 = mk(1, 2, 7, 1'b1, 1'b0, 1'b1, 1'b0);
      add7 = mk(7, 0, 8, 1'b1, 1'b0, 1'b0, 1'b0);
      addf = mk(1, 2, 9, 1'b1, 1'b0, 1'b0, 1'b0);

      hz_cnt     = 0;
      we_cnt     = 0;
      last_we_rd = '0;
      last_acc   = 1'b0;
      rst        = 1'b1;
      dec_valid  = 1'b0;
      dec_word   = '0;
      idle(2);
      rst = 1'b0;
      #1;

      chk("rst_dec_ready", {31'd0, dec_ready}, 32'd1);
      chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
      chk("rst_mul_busy", {31'd0, mul_busy}, 32'd0);
      chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);

      // Load r3 then ADD reading r3
      issue(ld3, stalls);
      chk("ld3_stalls", stalls, 0);
      hz_cnt = 0;
      issue(add3, stalls);
      chk("add3_stalls", stalls, 3);
      chk("add3_hz_cycles", hz_cnt, 3);
      chk("add3_ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("add3_ex_word", {9'd0, ex_word}, {9'd0, add3});
      idle(4);

      // Same sequence targeting r0: no stall
      issue(ld0, stalls);
      issue(add0, stalls);
      chk("r0_no_stall", stalls, 0);
      idle(4);

      // Load r5, load r5 (rt is destination), store reading r5
      issue(ld5, stalls);
      issue(ld5, stalls);
      chk("ld_ld_no_stall", stalls, 0);
      issue(st5, stalls);
      chk("ld_st_stalls", stalls, 3);
      idle(4);

      // MUL r7 then dependent ADD
      issue(mul7, stalls);
      we_cnt    = 0;
      ex_same   = 0;
      busy      = 0;
      mem_bub   = 0;
      stalls    = 0;
      done      = 1'b0;
      dec_valid = 1'b1;
      dec_word  = add7;
      for (int c = 0; c < 14 && !done; c++) begin
         if (ex_valid && ex_word == mul7) ex_same++;
         if (mul_busy) busy++;
         if (c >= 1 && c <= 3 && !mem_valid && mem_word == '0) mem_bub++;
         if (c == 4) chk("mul_mem_word", {9'd0, mem_word}, {9'd0, mul7});
         tick();
         if (last_acc) done = 1'b1;
         else stalls++;
      end
      dec_valid = 1'b0;
      dec_word  = '0;
      chk("mul_accept", {31'd0, done}, 32'd1);
      chk("mul_ex_cycles", ex_same, 4);
      chk("mul_busy_cycles", busy, 3);
      chk("mul_mem_bubbles", mem_bub, 3);
      chk("mul_add_stalls", stalls, 6);
      chk("mul_wb_we_pulses", we_cnt, 1);
      chk("mul_wb_rd", {27'd0, last_we_rd}, 32'd7);
      idle(4);

      // Reset on the second cycle of a multiply
      issue(mul7, stalls);
      tick();
      chk("mul2_busy_before", {31'd0, mul_busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmul_busy", {31'd0, mul_busy}, 32'd0);
      chk("rstmul_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rstmul_stage_words", {9'd0, ex_word | mem_word | wb_word}, 32'd0);
      chk("rstmul_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd0);
      issue(addf, stalls);
      chk("post_rst_stalls", stalls, 0);
      chk("post_rst_ex_word", {9'd0, ex_word}, {9'd0, addf});
      idle(4);
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
